// File: rtl/regfile_sb.sv
// Register file with per-register scoreboard busy bits and a running busy count; x0 is hardwired zero.
// Latency: reads are combinational, writes/allocs land at the rising edge (REGFILE_SB_BYPASS_EN forwards wb_data same cycle).
// Backpressure: none; every strobe is accepted on the edge it is presented.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_index,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_index,
    input  logic                flush,
    input  logic [NRD*AW-1:0]   rs_index,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    output logic [AW:0]         busy_count
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     busy_count_q;
    logic [AW:0]     busy_count_d;

    logic wb_eff;
    logic alloc_eff;
    logic cnt_inc;
    logic cnt_dec;

    assign wb_eff    = wb_en && (wb_index != '0);
    assign alloc_eff = alloc_en && (alloc_index != '0);

    always_comb begin
        regs_d = regs_q;
        if (wb_eff) begin
            regs_d[wb_index] = wb_data;
        end
    end

    // Order matters: flush clears first, wb clears its bit, alloc sets last so it wins.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end
        if (wb_eff) begin
            busy_d[wb_index] = 1'b0;
        end
        if (alloc_eff) begin
            busy_d[alloc_index] = 1'b1;
        end
    end

    always_comb begin
        cnt_inc      = alloc_eff && !busy_q[alloc_index];
        cnt_dec      = wb_eff && busy_q[wb_index]
                       && !(alloc_eff && (alloc_index == wb_index));
        busy_count_d = busy_count_q;
        if (flush) begin
            busy_count_d = {{AW{1'b0}}, alloc_eff};
        end else begin
            busy_count_d = busy_count_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q       <= '{default: '0};
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] idx;
        assign idx = rs_index[k*AW +: AW];
`ifdef REGFILE_SB_BYPASS_EN
        logic fwd;
        assign fwd = wb_eff && (idx == wb_index);
        assign rs_data[k*XLEN +: XLEN] = (idx == '0) ? '0 : (fwd ? wb_data : regs_q[idx]);
        assign rs_busy[k]              = (idx != '0) && !fwd && busy_q[idx];
`else
        assign rs_data[k*XLEN +: XLEN] = (idx == '0) ? '0 : regs_q[idx];
        assign rs_busy[k]              = (idx != '0) && busy_q[idx];
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: hand-computed expectations for reset, scoreboard, flush and bypass behaviour.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                wb_en;
    logic [AW-1:0]       wb_index;
    logic [XLEN-1:0]     wb_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_index;
    logic                flush;
    logic [NRD*AW-1:0]   rs_index;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic [AW:0]         busy_count;

    int n_cmp = 0;
    int n_err = 0;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_en       (wb_en),
        .wb_index    (wb_index),
        .wb_data     (wb_data),
        .alloc_en    (alloc_en),
        .alloc_index (alloc_index),
        .flush       (flush),
        .rs_index    (rs_index),
        .rs_data     (rs_data),
        .rs_busy     (rs_busy),
        .busy_count  (busy_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] rd(input int k);
        return rs_data[k*XLEN +: XLEN];
    endfunction

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rs_index = {a1, a0};
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wb_en    = 1'b0;
        alloc_en = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_alloc(input logic [AW-1:0] a);
        alloc_en    = 1'b1;
        alloc_index = a;
    endtask

    task automatic do_wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wb_en    = 1'b1;
        wb_index = a;
        wb_data  = d;
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        rs_index = '0;
        do_wb(5'd5, 32'h1111_2222);
        do_alloc(5'd6);
        repeat (3) @(posedge clk);
        #1;
        set_rd(5'd6, 5'd6);
        chk("rst_busy_x6", 64'(rs_busy), 64'h0);
        chk("rst_count", 64'(busy_count), 64'h0);
        wb_en    = 1'b0;
        alloc_en = 1'b0;
        rst_n    = 1'b1;
        set_rd(5'd5, 5'd5);
        chk("rst_data_x5", 64'(rd(0)), 64'h0);

        for (int i = 0; i < NREG; i++) begin
            set_rd(AW'(i), AW'(NREG - 1 - i));
            chk("init_rd0", 64'(rd(0)), 64'h0);
            chk("init_busy", 64'(rs_busy), 64'h0);
        end
        chk("init_count", 64'(busy_count), 64'h0);

        do_alloc(5'd5);
        tick();
        set_rd(5'd5, 5'd5);
        chk("alloc5_busy", 64'(rs_busy), 64'h3);
        chk("alloc5_count", 64'(busy_count), 64'h1);
        do_wb(5'd5, 32'hDEAD_BEEF);
        tick();
        set_rd(5'd5, 5'd5);
        chk("wb5_rd0", 64'(rd(0)), 64'hDEAD_BEEF);
        chk("wb5_rd1", 64'(rd(1)), 64'hDEAD_BEEF);
        chk("wb5_busy", 64'(rs_busy), 64'h0);
        chk("wb5_count", 64'(busy_count), 64'h0);

        do_alloc(5'd7);
        do_wb(5'd7, 32'h1234_5678);
        tick();
        set_rd(5'd7, 5'd0);
        chk("same7_data", 64'(rd(0)), 64'h1234_5678);
        chk("same7_busy", 64'(rs_busy), 64'h1);
        chk("same7_count", 64'(busy_count), 64'h1);

        for (int i = 1; i <= 4; i++) begin
            do_alloc(AW'(i));
            tick();
        end
        chk("alloc1to4_count", 64'(busy_count), 64'h5);
        flush = 1'b1;
        do_alloc(5'd9);
        tick();
        chk("flush_count", 64'(busy_count), 64'h1);
        set_rd(5'd9, 5'd7);
        chk("flush_busy_9_7", 64'(rs_busy), 64'h1);
        set_rd(5'd1, 5'd4);
        chk("flush_busy_1_4", 64'(rs_busy), 64'h0);

        do_wb(5'd0, 32'hFFFF_FFFF);
        do_alloc(5'd0);
        tick();
        set_rd(5'd0, 5'd0);
        chk("x0_data", 64'(rd(0)), 64'h0);
        chk("x0_busy", 64'(rs_busy), 64'h0);
        chk("x0_count", 64'(busy_count), 64'h1);

        do_alloc(5'd9);
        tick();
        chk("realloc9_count", 64'(busy_count), 64'h1);
        do_wb(5'd2, 32'hCAFE_F00D);
        tick();
        set_rd(5'd2, 5'd9);
        chk("wb_idle2_count", 64'(busy_count), 64'h1);
        chk("wb_idle2_data", 64'(rd(0)), 64'hCAFE_F00D);
        chk("wb_idle2_busy", 64'(rs_busy), 64'h2);

        do_alloc(5'd10);
        do_wb(5'd9, 32'h0000_0099);
        tick();
        set_rd(5'd10, 5'd9);
        chk("swap_count", 64'(busy_count), 64'h1);
        chk("swap_busy", 64'(rs_busy), 64'h1);
        chk("swap_data9", 64'(rd(1)), 64'h99);

        do_alloc(5'd11);
        tick();
        chk("alloc11_count", 64'(busy_count), 64'h2);
        flush = 1'b1;
        do_wb(5'd11, 32'h0000_00BB);
        tick();
        set_rd(5'd11, 5'd10);
        chk("flushwb_count", 64'(busy_count), 64'h0);
        chk("flushwb_data", 64'(rd(0)), 64'hBB);
        chk("flushwb_busy", 64'(rs_busy), 64'h0);

        do_wb(5'd3, 32'h0000_0011);
        tick();
        do_alloc(5'd3);
        tick();
        chk("alloc3_count", 64'(busy_count), 64'h1);
        do_wb(5'd3, 32'hA5A5_A5A5);
        set_rd(5'd3, 5'd3);
`ifdef REGFILE_SB_BYPASS_EN
        chk("byp3_data", 64'(rd(0)), 64'hA5A5_A5A5);
        chk("byp3_busy", 64'(rs_busy), 64'h0);
`else
        chk("nobyp3_data", 64'(rd(0)), 64'h11);
        chk("nobyp3_busy", 64'(rs_busy), 64'h3);
`endif
        tick();
        set_rd(5'd3, 5'd3);
        chk("wb3_data", 64'(rd(1)), 64'hA5A5_A5A5);
        chk("wb3_busy", 64'(rs_busy), 64'h0);
        chk("wb3_count", 64'(busy_count), 64'h0);

        for (int i = 1; i < NREG; i++) begin
            do_alloc(AW'(i));
            tick();
        end
        chk("full_count", 64'(busy_count), 64'd31);
        do_alloc(5'd0);
        tick();
        chk("full_x0_count", 64'(busy_count), 64'd31);
        flush = 1'b1;
        tick();
        chk("full_flush_count", 64'(busy_count), 64'h0);

        do_alloc(5'd12);
        tick();
        do_alloc(5'd14);
        do_wb(5'd13, 32'h0000_0077);
        #2;
        rst_n = 1'b0;
        #1;
        set_rd(5'd3, 5'd12);
        chk("midrst_count", 64'(busy_count), 64'h0);
        chk("midrst_data3", 64'(rd(0)), 64'h0);
        chk("midrst_busy", 64'(rs_busy), 64'h0);
        @(posedge clk);
        #1;
        chk("inrst_count", 64'(busy_count), 64'h0);
        rst_n = 1'b1;
        tick();
        set_rd(5'd14, 5'd13);
        chk("postrst_count", 64'(busy_count), 64'h1);
        chk("postrst_busy", 64'(rs_busy), 64'h1);
        chk("postrst_data13", 64'(rd(1)), 64'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32: register data width in bits.
REQ-002 Parameter NREG, default 32: number of architectural registers, power of two, at least 2; AW = clog2(NREG).
REQ-003 Parameter NRD, default 2: number of read ports, at least 1.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 wb_en  in  1  writeback strobe.
REQ-007 wb_index  in  AW  writeback destination register.
REQ-008 wb_data  in  XLEN  writeback data.
REQ-009 alloc_en  in  1  marks a register as awaiting a result (issue).
REQ-010 alloc_index  in  AW  register to mark busy.
REQ-011 flush  in  1  clears all busy bits (pipeline squash).
REQ-012 rs_index  in  NRD*AW  read indices; port k occupies bits [k*AW +: AW].
REQ-013 rs_data  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
REQ-014 rs_busy  out  NRD  per-port busy flag of the addressed register.
REQ-015 busy_count  out  AW+1  number of registers currently marked busy.

Function
REQ-016 Register 0 SHALL read as zero with rs_busy 0; writes and allocs to index 0 SHALL be ignored and SHALL NOT change busy_count.
REQ-017 Reads SHALL be combinational: rs_data and rs_busy reflect the stored state of the addressed register in the same cycle.
REQ-018 On a rising edge with wb_en=1 and wb_index!=0, the register SHALL take wb_data and its busy bit SHALL clear.
REQ-019 On a rising edge with alloc_en=1 and alloc_index!=0, that register's busy bit SHALL set.
REQ-020 If alloc and wb target the same register in one cycle, the data SHALL be written and the busy bit SHALL end set (alloc wins).
REQ-021 flush=1 SHALL clear every busy bit at the edge; a concurrent alloc SHALL still set its own bit; a concurrent wb SHALL still write data.
REQ-022 Alloc to an already-busy register SHALL leave it busy with no count change; wb to a non-busy register SHALL write data with no count change.
REQ-023 busy_count SHALL always equal the population count of the busy bits after each edge; it SHALL be maintained incrementally (+1, -1, 0 per edge, or reload on flush), never exceeding NREG-1.
REQ-024 Multiple read ports addressing the same register SHALL return identical values.

Reset
REQ-025 While rst_n=0, all registers SHALL be zero, all busy bits 0, and busy_count 0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard pending writes and allocs; the first edge after deassertion SHALL behave as a normal cycle.

Configuration
REQ-027 Macro REGFILE_SB_BYPASS_EN: when defined, a read port whose index equals wb_index with wb_en=1 and index!=0 SHALL return wb_data and rs_busy=0 in the same cycle.
REQ-028 Without REGFILE_SB_BYPASS_EN, reads SHALL return the stored value and stored busy bit only; the new data is visible the cycle after the write.

Verification
REQ-029 Reset, then read all indices -> rs_data 0, rs_busy 0, busy_count 0.
REQ-030 Alloc x5, next cycle wb x5=0xDEADBEEF -> after alloc, rs_busy=1 and busy_count=1; after wb, data 0xDEADBEEF, rs_busy=0, busy_count=0.
REQ-031 Same-cycle alloc and wb on x7 with data 0x12345678 -> x7 reads 0x12345678, rs_busy=1, busy_count=1.
REQ-032 Alloc x1..x4, then flush together with alloc x9 -> busy_count=1, only x9 busy.
REQ-033 wb x0=0xFFFFFFFF with alloc x0 -> x0 reads 0, busy 0, busy_count unchanged.
REQ-034 Port 0 reads x3 while wb x3=0xA5A5A5A5 -> with REGFILE_SB_BYPASS_EN, 0xA5A5A5A5 in the same cycle; without it, the old value, then 0xA5A5A5A5 the next cycle.
